// File: rtl/acc_subwsat.sv
// Saturating signed accumulator: adds or subtracts a burst of N_SAMPLES operands
// received over valid/ready, clamps on overflow, then holds the total until acknowledged.
module acc_subwsat #(
   parameter int NB_size   = 16,
   parameter int N_SAMPLES = 4,
   parameter int NB_cnt    = 4
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_op,
   input  logic               i_valid,
   input  logic [NB_size-1:0] i_data,
   output logic               o_ready,
   output logic               o_valid,
   output logic [NB_size-1:0] o_result,
   input  logic               i_ack,
   output logic               o_ovf_sticky,
   output logic [NB_cnt-1:0]  o_ovf_count
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   localparam int NB_smp = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam logic [NB_smp-1:0]  LAST_SMP = NB_smp'(N_SAMPLES - 1);
   localparam logic [NB_size-1:0] SAT_POS  = {1'b0, {(NB_size-1){1'b1}}};
   localparam logic [NB_size-1:0] SAT_NEG  = {1'b1, {(NB_size-1){1'b0}}};
   localparam logic [NB_cnt-1:0]  CNT_MAX  = '1;

   state_t              state;
   state_t              state_next;
   logic [NB_size-1:0]  acc;
   logic [NB_size-1:0]  acc_next;
   logic [NB_smp-1:0]   smp_cnt;
   logic [NB_smp-1:0]   smp_cnt_next;
   logic                op;
   logic                op_next;
   logic                sticky;
   logic                sticky_next;
   logic [NB_cnt-1:0]   ovf_cnt;
   logic [NB_cnt-1:0]   ovf_cnt_next;
   logic [NB_size-1:0]  sum;
   logic                ovf;
   logic                transfer;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state   <= IDLE;
         acc     <= '0;
         smp_cnt <= '0;
         op      <= 1'b0;
         sticky  <= 1'b0;
         ovf_cnt <= '0;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         smp_cnt <= smp_cnt_next;
         op      <= op_next;
         sticky  <= sticky_next;
         ovf_cnt <= ovf_cnt_next;
      end
   end

   // Sign-rule overflow: subtracting flips the sign of the operand, so the
   // operand-sign condition inverts between add and subtract.
   always_comb begin
      sum      = op ? (acc - i_data) : (acc + i_data);
      transfer = (state == ACC) && i_valid;
      if (op) begin
         ovf = (acc[NB_size-1] != i_data[NB_size-1]) && (sum[NB_size-1] != acc[NB_size-1]);
      end else begin
         ovf = (acc[NB_size-1] == i_data[NB_size-1]) && (sum[NB_size-1] != acc[NB_size-1]);
      end
   end

   always_comb begin
      state_next   = state;
      acc_next     = acc;
      smp_cnt_next = smp_cnt;
      op_next      = op;
      sticky_next  = sticky;
      ovf_cnt_next = ovf_cnt;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next   = ACC;
               acc_next     = '0;
               smp_cnt_next = '0;
               sticky_next  = 1'b0;
               ovf_cnt_next = '0;
               op_next      = i_op;
            end
         end
         ACC: begin
            if (transfer) begin
               if (ovf) begin
                  acc_next    = acc[NB_size-1] ? SAT_NEG : SAT_POS;
                  sticky_next = 1'b1;
                  if (ovf_cnt != CNT_MAX) begin
                     ovf_cnt_next = ovf_cnt + NB_cnt'(1);
                  end
               end else begin
                  acc_next = sum;
               end
               if (smp_cnt == LAST_SMP) begin
                  smp_cnt_next = '0;
                  state_next   = DONE;
               end else begin
                  smp_cnt_next = smp_cnt + NB_smp'(1);
               end
            end
         end
         DONE: begin
            if (i_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign o_ready      = (state == ACC);
   assign o_valid      = (state == DONE);
   assign o_result     = acc;
   assign o_ovf_sticky = sticky;
   assign o_ovf_count  = ovf_cnt;

endmodule

// File: tb/tb_acc_subwsat.sv
// Directed bench for acc_subwsat: add/subtract bursts, saturation, backpressure,
// mid-burst reset, ignored controls and a 1-bit overflow counter instance.
module tb_acc_subwsat;

   logic        clk;
   logic        i_reset;
   logic        i_start;
   logic        i_op;
   logic        i_valid;
   logic [15:0] i_data;
   logic        i_ack;

   logic        o_ready;
   logic        o_valid;
   logic [15:0] o_result;
   logic        o_ovf_sticky;
   logic [3:0]  o_ovf_count;

   logic        n_ready;
   logic        n_valid;
   logic [15:0] n_result;
   logic        n_ovf_sticky;
   logic [0:0]  n_ovf_count;

   int total;
   int bad;

   acc_subwsat #(.NB_size(16), .N_SAMPLES(4), .NB_cnt(4)) u_dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_op         (i_op),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_result     (o_result),
      .i_ack        (i_ack),
      .o_ovf_sticky (o_ovf_sticky),
      .o_ovf_count  (o_ovf_count)
   );

   // Second instance shares the stimulus; only used to see a 1-bit counter saturate.
   acc_subwsat #(.NB_size(16), .N_SAMPLES(4), .NB_cnt(1)) u_dut_narrow (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_op         (i_op),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_ready      (n_ready),
      .o_valid      (n_valid),
      .o_result     (n_result),
      .i_ack        (i_ack),
      .o_ovf_sticky (n_ovf_sticky),
      .o_ovf_count  (n_ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rst, input logic start, input logic op,
                                input logic valid, input int data, input logic ack);
      i_reset = rst;
      i_start = start;
      i_op    = op;
      i_valid = valid;
      i_data  = 16'(data);
      i_ack   = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkMain(input string tag, input logic rdy, input logic vld,
                            input int res, input logic stk, input int cnt);
      checkOutput({tag, ".ready"},  32'(o_ready), 32'(rdy));
      checkOutput({tag, ".valid"},  32'(o_valid), 32'(vld));
      checkOutput({tag, ".result"}, 32'($signed(o_result)), res);
      checkOutput({tag, ".sticky"}, 32'(o_ovf_sticky), 32'(stk));
      checkOutput({tag, ".count"},  32'(o_ovf_count), cnt);
   endtask

   task automatic feed(input string tag, input int data, input logic rdy, input logic vld,
                       input int res, input logic stk, input int cnt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, data, 1'b0);
      checkMain(tag, rdy, vld, res, stk, cnt);
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 123, 1'b1);
      checkMain("reset", 1'b0, 1'b0, 0, 1'b0, 0);

      // Add burst 100, 200, -50, 7
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checkMain("add.start", 1'b1, 1'b0, 0, 1'b0, 0);
      feed("add.d0", 100, 1'b1, 1'b0, 100, 1'b0, 0);
      feed("add.d1", 200, 1'b1, 1'b0, 300, 1'b0, 0);
      feed("add.d2", -50, 1'b1, 1'b0, 250, 1'b0, 0);
      feed("add.d3", 7,   1'b0, 1'b1, 257, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkMain("add.ack", 1'b0, 1'b0, 257, 1'b0, 0);

      // Add with positive overflow, then recovering below full scale
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checkMain("sat.start", 1'b1, 1'b0, 0, 1'b0, 0);
      feed("sat.d0", 20000, 1'b1, 1'b0, 20000, 1'b0, 0);
      feed("sat.d1", 20000, 1'b1, 1'b0, 32767, 1'b1, 1);
      feed("sat.d2", -1,    1'b1, 1'b0, 32766, 1'b1, 1);
      feed("sat.d3", 1,     1'b0, 1'b1, 32767, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkMain("sat.ack", 1'b0, 1'b0, 32767, 1'b1, 1);

      // Subtract burst: overflow both directions
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      checkMain("sub.start", 1'b1, 1'b0, 0, 1'b0, 0);
      feed("sub.d0", -32768, 1'b1, 1'b0, 32767,  1'b1, 1);
      feed("sub.d1", 32767,  1'b1, 1'b0, 0,      1'b1, 1);
      feed("sub.d2", 32767,  1'b1, 1'b0, -32767, 1'b1, 1);
      feed("sub.d3", 2,      1'b0, 1'b1, -32768, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkMain("sub.ack", 1'b0, 1'b0, -32768, 1'b1, 2);

      // Backpressure: valid gaps stall, DONE holds while ack is low
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      feed("bp.d0", 5, 1'b1, 1'b0, 5, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 77, 1'b0);
      checkMain("bp.gap0", 1'b1, 1'b0, 5, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 88, 1'b0);
      checkMain("bp.gap1", 1'b1, 1'b0, 5, 1'b0, 0);
      feed("bp.d1", 6, 1'b1, 1'b0, 11, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 99, 1'b0);
      checkMain("bp.gap2", 1'b1, 1'b0, 11, 1'b0, 0);
      feed("bp.d2", 7, 1'b1, 1'b0, 18, 1'b0, 0);
      feed("bp.d3", 8, 1'b0, 1'b1, 26, 1'b0, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, (k == 2), 1'b1, 1'b1, 1000, 1'b0);
         checkMain("bp.hold", 1'b0, 1'b1, 26, 1'b0, 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkMain("bp.ack", 1'b0, 1'b0, 26, 1'b0, 0);

      // Immediate restart after ack, then reset in mid-burst with overflow pending
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checkMain("rst.start", 1'b1, 1'b0, 0, 1'b0, 0);
      feed("rst.d0", 30000, 1'b1, 1'b0, 30000, 1'b0, 0);
      feed("rst.d1", 30000, 1'b1, 1'b0, 32767, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 70, 1'b0);
      checkMain("rst.mid", 1'b0, 1'b0, 0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 70, 1'b0);
      checkMain("rst.idle", 1'b0, 1'b0, 0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      feed("rst.d2", 1, 1'b1, 1'b0, 1,  1'b0, 0);
      feed("rst.d3", 2, 1'b1, 1'b0, 3,  1'b0, 0);
      feed("rst.d4", 3, 1'b1, 1'b0, 6,  1'b0, 0);
      feed("rst.d5", 4, 1'b0, 1'b1, 10, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

      // Ignored controls: start/op in ACC and DONE, ack in ACC, valid in IDLE
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10, 1'b0);
      checkMain("ign.d0", 1'b1, 1'b0, 10, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 20, 1'b1);
      checkMain("ign.d1", 1'b1, 1'b0, 30, 1'b0, 0);
      feed("ign.d2", 30, 1'b1, 1'b0, 60,  1'b0, 0);
      feed("ign.d3", 40, 1'b0, 1'b1, 100, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 55, 1'b0);
      checkMain("ign.done", 1'b0, 1'b1, 100, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 999, 1'b0);
      checkMain("ign.idle", 1'b0, 1'b0, 100, 1'b0, 0);

      // Three overflows: 4-bit counter reaches 3, 1-bit counter pins at 1
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      feed("cnt.d0", 30000, 1'b1, 1'b0, 30000, 1'b0, 0);
      feed("cnt.d1", 30000, 1'b1, 1'b0, 32767, 1'b1, 1);
      feed("cnt.d2", 30000, 1'b1, 1'b0, 32767, 1'b1, 2);
      feed("cnt.d3", 30000, 1'b0, 1'b1, 32767, 1'b1, 3);
      checkOutput("cnt.narrow.count",  32'(n_ovf_count), 1);
      checkOutput("cnt.narrow.sticky", 32'(n_ovf_sticky), 1);
      checkOutput("cnt.narrow.valid",  32'(n_valid), 1);
      checkOutput("cnt.narrow.result", 32'($signed(n_result)), 32767);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkMain("cnt.ack", 1'b0, 1'b0, 32767, 1'b1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
